// File: rtl/cfg_serial_writer.sv
// Serial configuration-bus master: takes (address, value) writes and shifts each value out LSB first.
// Define CFG_WRITER_SHADOW_EN to add per-register shadow copies with a combinational rd_addr/rd_data readback.
module cfg_serial_writer #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REGS     = 8,
    parameter int PHASE_CYCLES = 2
) (
    input  logic                        ps_clk,
    input  logic                        rst,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [$clog2(NUM_REGS)-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    output logic                        sdata,
    output logic [NUM_REGS-1:0]         reg_clk,
    output logic                        select,
    output logic                        busy,
    output logic                        done,
    output logic                        addr_err
`ifdef CFG_WRITER_SHADOW_EN
    ,
    input  logic [$clog2(NUM_REGS)-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]       rd_data
`endif
);
    localparam int ADDR_W = $clog2(NUM_REGS);
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int PH_W   = $clog2(PHASE_CYCLES) + 1;
    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(DATA_WIDTH - 1);
    localparam logic [PH_W-1:0]   PH_LAST    = PH_W'(PHASE_CYCLES - 1);
    localparam logic [ADDR_W:0]   NUM_REGS_W = NUM_REGS[ADDR_W:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_SETUP,
        S_HIGH,
        S_HOLD,
        S_TRAIL
    } state_t;

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [ADDR_W-1:0]       r_addr;
    logic [BIT_W-1:0]        r_bit_cnt;
    logic [PH_W-1:0]         r_phase_cnt;
    logic                    r_sdata;
    logic [NUM_REGS-1:0]     r_reg_clk;
    logic                    r_select;
    logic                    r_done;
    logic                    r_addr_err;

    logic                    w_addr_ok;
    logic                    w_phase_end;
    logic [NUM_REGS-1:0]     w_clk_sel;
    logic [DATA_WIDTH-1:0]   w_shift_next;

    assign w_addr_ok    = ({1'b0, r_addr} < NUM_REGS_W);
    assign w_phase_end  = (r_phase_cnt == PH_LAST);
    assign w_shift_next = r_shift >> 1;

    // An out-of-range address matches no line, so the frame runs with every reg_clk quiet.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_clk_sel
        localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
        assign w_clk_sel[gi] = (r_addr == IDX);
    end

    always_ff @(posedge ps_clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_addr      <= '0;
            r_bit_cnt   <= '0;
            r_phase_cnt <= '0;
            r_sdata     <= 1'b0;
            r_reg_clk   <= '0;
            r_select    <= 1'b0;
            r_done      <= 1'b0;
            r_addr_err  <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_addr_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (wr_valid) begin
                        r_shift  <= wr_data;
                        r_addr   <= wr_addr;
                        r_select <= 1'b1;
                        r_state  <= S_LEAD;
                    end
                end
                S_LEAD: begin
                    r_sdata     <= r_shift[0];
                    r_bit_cnt   <= '0;
                    r_phase_cnt <= '0;
                    r_state     <= S_SETUP;
                end
                S_SETUP: begin
                    if (w_phase_end) begin
                        r_phase_cnt <= '0;
                        r_reg_clk   <= w_clk_sel;
                        r_state     <= S_HIGH;
                    end else begin
                        r_phase_cnt <= r_phase_cnt + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (w_phase_end) begin
                        r_phase_cnt <= '0;
                        r_reg_clk   <= '0;
                        r_state     <= S_HOLD;
                    end else begin
                        r_phase_cnt <= r_phase_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_phase_end) begin
                        r_phase_cnt <= '0;
                        if (r_bit_cnt == BIT_LAST) begin
                            r_sdata <= 1'b0;
                            r_state <= S_TRAIL;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_shift   <= w_shift_next;
                            r_sdata   <= w_shift_next[0];
                            r_state   <= S_SETUP;
                        end
                    end else begin
                        r_phase_cnt <= r_phase_cnt + 1'b1;
                    end
                end
                S_TRAIL: begin
                    r_select   <= 1'b0;
                    r_done     <= 1'b1;
                    r_addr_err <= ~w_addr_ok;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Gated by rst so the writer never advertises readiness while held in reset.
    assign wr_ready = rst && (r_state == S_IDLE);
    assign sdata    = r_sdata;
    assign reg_clk  = r_reg_clk;
    assign select   = r_select;
    assign busy     = r_select;
    assign done     = r_done;
    assign addr_err = r_addr_err;

`ifdef CFG_WRITER_SHADOW_EN
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_shadow [NUM_REGS];
    logic                  w_shadow_we;

    // The shift register is consumed during the frame, so the value is kept separately.
    always_ff @(posedge ps_clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
        end else if (wr_valid && wr_ready) begin
            r_data <= wr_data;
        end
    end

    assign w_shadow_we = (r_state == S_TRAIL) && w_addr_ok;

    always_ff @(posedge ps_clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_shadow_we) begin
            r_shadow[r_addr] <= r_data;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_data = r_shadow[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_cfg_serial_writer.sv
// Randomised bench for cfg_serial_writer: two configurations checked against a receiver/scoreboard model.
`timescale 1ns/1ps
module tb_cfg_serial_writer;
    localparam int A_DW = 16;
    localparam int A_NR = 6;
    localparam int A_P  = 2;
    localparam int A_LEN = 2 + A_DW * 3 * A_P;
    localparam int B_DW = 32;
    localparam int B_NR = 8;
    localparam int B_P  = 1;
    localparam int B_LEN = 2 + B_DW * 3 * B_P;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic              a_valid, a_ready, a_sdata, a_select, a_busy, a_done, a_err;
    logic [2:0]        a_addr;
    logic [A_DW-1:0]   a_data;
    logic [A_NR-1:0]   a_reg_clk;
    logic              b_valid, b_ready, b_sdata, b_select, b_busy, b_done, b_err;
    logic [2:0]        b_addr;
    logic [B_DW-1:0]   b_data;
    logic [B_NR-1:0]   b_reg_clk;
`ifdef CFG_WRITER_SHADOW_EN
    logic [2:0]        a_rd_addr, b_rd_addr;
    logic [A_DW-1:0]   a_rd_data;
    logic [B_DW-1:0]   b_rd_data;
`endif

    cfg_serial_writer #(.DATA_WIDTH(A_DW), .NUM_REGS(A_NR), .PHASE_CYCLES(A_P)) u_dut_a (
        .ps_clk(clk), .rst(rst), .wr_valid(a_valid), .wr_ready(a_ready),
        .wr_addr(a_addr), .wr_data(a_data), .sdata(a_sdata), .reg_clk(a_reg_clk),
        .select(a_select), .busy(a_busy), .done(a_done), .addr_err(a_err)
`ifdef CFG_WRITER_SHADOW_EN
        , .rd_addr(a_rd_addr), .rd_data(a_rd_data)
`endif
    );

    cfg_serial_writer #(.DATA_WIDTH(B_DW), .NUM_REGS(B_NR), .PHASE_CYCLES(B_P)) u_dut_b (
        .ps_clk(clk), .rst(rst), .wr_valid(b_valid), .wr_ready(b_ready),
        .wr_addr(b_addr), .wr_data(b_data), .sdata(b_sdata), .reg_clk(b_reg_clk),
        .select(b_select), .busy(b_busy), .done(b_done), .addr_err(b_err)
`ifdef CFG_WRITER_SHADOW_EN
        , .rd_addr(b_rd_addr), .rd_data(b_rd_data)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          hs;
    } xact_t;

    xact_t qa[$];
    xact_t qb[$];

    // ---------------- receiver / scoreboard for configuration A ----------------
    logic [A_NR-1:0] a_rc_q = '0;
    logic            a_busy_q = 1'b0;
    logic            a_sd_q = 1'b0;
    int              a_pulses [A_NR];
    int              a_hi [A_NR];
    logic [A_DW-1:0] a_rx [A_NR];
    int              a_last_chg = -1000;
    int              a_last_fall = -1000;
    int              a_stab_bad = 0;
    int              a_frm_bad = 0;
    int              a_idle_run = 0;
    int              a_gap = 0;
    xact_t           xa;

    always @(negedge clk) begin
        if (!rst) begin
            a_rc_q = '0;
            a_busy_q = 1'b0;
            a_sd_q = a_sdata;
            a_last_fall = -1000;
        end else begin
            if (a_valid && a_ready) qa.push_back('{int'(a_addr), 32'(a_data), cyc + 1});
            if (a_busy && a_ready) a_frm_bad++;
            if (a_select != a_busy) a_frm_bad++;
            if (a_err && !a_done) a_frm_bad++;
            if ($countones(a_reg_clk) > 1) a_frm_bad++;
            if (a_busy && !a_busy_q) begin
                a_gap = a_idle_run;
                for (int i = 0; i < A_NR; i++) begin
                    a_pulses[i] = 0;
                    a_hi[i] = 0;
                end
            end
            a_idle_run = a_busy ? 0 : a_idle_run + 1;
            if (a_sdata != a_sd_q) begin
                a_last_chg = cyc;
                if (cyc - a_last_fall < A_P) a_stab_bad++;
            end
            for (int i = 0; i < A_NR; i++) begin
                if (a_reg_clk[i] && !a_rc_q[i]) begin
                    a_pulses[i]++;
                    a_rx[i] = {a_sdata, a_rx[i][A_DW-1:1]};
                    if (cyc - a_last_chg < A_P) a_stab_bad++;
                end
                if (!a_reg_clk[i] && a_rc_q[i]) a_last_fall = cyc;
                if (a_reg_clk[i]) a_hi[i]++;
            end
            if (a_done) begin
                chk("A_done_expected", qa.size() > 0, 1'b1);
                if (qa.size() > 0) begin
                    xa = qa.pop_front();
                    $display("A frame: addr=%0d data=0x%04h latency=%0d addr_err=%0b",
                             xa.addr, xa.data[15:0], cyc - xa.hs, a_err);
                    chk("A_latency", cyc - xa.hs, A_LEN);
                    chk("A_addr_err", a_err, xa.addr >= A_NR);
                    chk("A_busy_at_done", a_busy, 1'b0);
                    for (int i = 0; i < A_NR; i++)
                        chk("A_reg_clk_pulses", a_pulses[i], (i == xa.addr) ? A_DW : 0);
                    if (xa.addr < A_NR) begin
                        chk("A_rx_value", a_rx[xa.addr], xa.data[A_DW-1:0]);
                        chk("A_high_cycles", a_hi[xa.addr], A_DW * A_P);
                    end
                    chk("A_sdata_stability", a_stab_bad, 0);
                    chk("A_frame_rules", a_frm_bad, 0);
                end
            end
            a_rc_q = a_reg_clk;
            a_busy_q = a_busy;
            a_sd_q = a_sdata;
        end
    end

    // ---------------- receiver / scoreboard for configuration B ----------------
    logic [B_NR-1:0] b_rc_q = '0;
    logic            b_busy_q = 1'b0;
    int              b_pulses [B_NR];
    logic [B_DW-1:0] b_rx [B_NR];
    xact_t           xb;

    always @(negedge clk) begin
        if (!rst) begin
            b_rc_q = '0;
            b_busy_q = 1'b0;
        end else begin
            if (b_valid && b_ready) qb.push_back('{int'(b_addr), b_data, cyc + 1});
            if (b_busy && !b_busy_q)
                for (int i = 0; i < B_NR; i++) b_pulses[i] = 0;
            for (int i = 0; i < B_NR; i++) begin
                if (b_reg_clk[i] && !b_rc_q[i]) begin
                    b_pulses[i]++;
                    b_rx[i] = {b_sdata, b_rx[i][B_DW-1:1]};
                end
            end
            if (b_done) begin
                chk("B_done_expected", qb.size() > 0, 1'b1);
                if (qb.size() > 0) begin
                    xb = qb.pop_front();
                    $display("B frame: addr=%0d data=0x%08h latency=%0d", xb.addr, xb.data, cyc - xb.hs);
                    chk("B_latency", cyc - xb.hs, B_LEN);
                    chk("B_addr_err", b_err, 1'b0);
                    chk("B_reg_clk_pulses", b_pulses[xb.addr], B_DW);
                    chk("B_rx_value", b_rx[xb.addr], xb.data);
                end
            end
            b_rc_q = b_reg_clk;
            b_busy_q = b_busy;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic write_a(input int addr, input logic [A_DW-1:0] data);
        int k;
        a_addr = 3'(addr);
        a_data = data;
        a_valid = 1'b1;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (a_ready) break;
        end
        chk("A_accept_timeout", k < 400, 1'b1);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
    endtask

    task automatic wait_idle_a();
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (qa.size() == 0) break;
        end
        chk("A_done_timeout", qa.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic write_b(input int addr, input logic [B_DW-1:0] data);
        int k;
        b_addr = 3'(addr);
        b_data = data;
        b_valid = 1'b1;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (b_ready) break;
        end
        chk("B_accept_timeout", k < 400, 1'b1);
        @(posedge clk);
        #1;
        b_valid = 1'b0;
    endtask

    task automatic wait_idle_b();
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (qb.size() == 0) break;
        end
        chk("B_done_timeout", qb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1);
    end

    initial begin
        int k;
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
`ifdef CFG_WRITER_SHADOW_EN
        a_rd_addr = 3'd3;
        b_rd_addr = 3'd0;
`endif
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("RST_a_outputs", {a_sdata, a_reg_clk, a_select, a_busy, a_done, a_err, a_ready}, '0);
        chk("RST_b_outputs", {b_sdata, b_reg_clk, b_select, b_busy, b_done, b_err, b_ready}, '0);
        rst = 1'b1;
        #1;
        chk("RST_a_ready_release", a_ready, 1'b1);
        @(posedge clk);
        #1;

        // single write, one hot bit
        write_a(1, 16'h0004);
        wait_idle_a();

        // two queued writes with wr_valid held high across the frame boundary
        a_addr = 3'd0; a_data = 16'h1234; a_valid = 1'b1;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (a_ready) break;
        end
        @(posedge clk);
        #1;
        a_addr = 3'd2; a_data = 16'hFFFF;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (a_ready) break;
        end
        chk("A_b2b_accept_timeout", k < 400, 1'b1);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        wait_idle_a();
        chk("A_b2b_gap", a_gap, 1);

        // out-of-range addresses
        write_a(7, 16'hBEEF);
        wait_idle_a();
        write_a(6, 16'h5A5A);
        wait_idle_a();

        // random writes with random idle spacing
        for (int n = 0; n < 10; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            write_a(int'($urandom_range(0, 7)), 16'($urandom));
            wait_idle_a();
        end

        // reset in the middle of bit 5
        write_a(4, 16'($urandom));
        repeat (1 + 5 * 3 * A_P + 1) @(posedge clk);
        #3;
        chk("RST_mid_frame_busy", a_busy, 1'b1);
        rst = 1'b0;
        #1;
        chk("RST_mid_outputs", {a_sdata, a_reg_clk, a_select, a_busy, a_done, a_err, a_ready}, '0);
        qa.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("RST_mid_ready_low", a_ready, 1'b0);
        rst = 1'b1;
        #1;
        chk("RST_mid_ready_release", a_ready, 1'b1);
        @(posedge clk);
        #1;
        write_a(4, 16'hA5A5);
        wait_idle_a();

`ifdef CFG_WRITER_SHADOW_EN
        a_rd_addr = 3'd3;
        write_a(3, 16'hDEAD);
        #1;
        chk("SHD_before_done", a_rd_data, 16'h0000);
        wait_idle_a();
        chk("SHD_after_done", a_rd_data, 16'hDEAD);
        a_rd_addr = 3'd7;
        #1;
        chk("SHD_out_of_range", a_rd_data, 16'h0000);
        a_rd_addr = 3'd4;
        #1;
        chk("SHD_addr4", a_rd_data, 16'hA5A5);
`endif

        // single-cycle phases, 32-bit word
        write_b(5, 32'h8000_0001);
        wait_idle_b();
        for (int n = 0; n < 4; n++) begin
            write_b(int'($urandom_range(0, 7)), $urandom);
            wait_idle_b();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
